// File: rtl/scoreboard_reg_file.sv
// scoreboard_reg_file
//
// Architectural register file with several read and writeback ports and a
// per-register pending-write counter. Decode reads operands, marks pending
// writers and squashes cancelled ones; writeback commits data and retires
// one pending writer per port hit.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   stackptr     reset value loaded into x2
//   rs_addr      packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rs_data      packed combinational read data
//   rs_busy      per read port, register still has a pending writer
//   raw_hazard   OR of rs_busy
//   wr_en        per writeback port valid
//   wr_addr      packed writeback destinations
//   wr_data      packed writeback data
//   wr_done      wr_en delayed by one cycle
//   mark_en      decode schedules a writer for mark_addr
//   mark_addr    scheduled destination
//   mark_full    mark_addr counter saturated, mark is refused
//   squash_en    cancel one pending writer of squash_addr
//   squash_addr  register of the cancelled writer
//   flush        clear every pending counter
//   registers    debug view of all register contents
module scoreboard_reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int PEND_WIDTH = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [DATA_WIDTH-1:0]                       stackptr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]              rs_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]              rs_data,
  output logic [NUM_READ-1:0]                         rs_busy,
  output logic                                        raw_hazard,
  input  logic [NUM_WRITE-1:0]                        wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]             wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]             wr_data,
  output logic [NUM_WRITE-1:0]                        wr_done,
  input  logic                                        mark_en,
  input  logic [ADDR_WIDTH-1:0]                       mark_addr,
  output logic                                        mark_full,
  input  logic                                        squash_en,
  input  logic [ADDR_WIDTH-1:0]                       squash_addr,
  input  logic                                        flush,
  output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]    registers
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  // Wide enough for count + one mark, and for up to NUM_WRITE+1 decrements.
  localparam int CW = PEND_WIDTH + $clog2(NUM_WRITE + 2);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

  logic [NUM_REGS-1:0][PEND_WIDTH-1:0] pend_count;
  logic [NUM_REGS-1:0][PEND_WIDTH-1:0] pend_next;

  logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wd [NUM_WRITE];

  logic [CW-1:0]         cnt_inc;
  logic [CW-1:0]         cnt_dec;
  logic [CW-1:0]         cnt_base;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         rd_hits;
  logic [DATA_WIDTH-1:0] rd_byp;

  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      wa[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      wd[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Looks at the count before this cycle's decrements, so a saturated
  // register refuses a mark even if a writeback retires it in the same cycle.
  assign mark_full = (mark_addr != '0) && (pend_count[mark_addr] == PEND_MAX);

  // Counter next state. The mark is added before the decrements are taken
  // off so a mark and a writeback to the same register cancel out instead of
  // underflowing; anything below zero clamps. Flush drops all history and
  // keeps only an accepted mark from this cycle. x0 never holds a count.
  always_comb begin
    pend_next = '0;
    cnt_inc   = '0;
    cnt_dec   = '0;
    cnt_base  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_inc = CW'(mark_en && !mark_full && (mark_addr == ADDR_WIDTH'(r)));
      cnt_dec = CW'(squash_en && (squash_addr == ADDR_WIDTH'(r)));
      for (int w = 0; w < NUM_WRITE; w++) begin
        cnt_dec = cnt_dec + CW'(wr_en[w] && (wa[w] == ADDR_WIDTH'(r)));
      end
      cnt_base = CW'(pend_count[r]) + cnt_inc;
      if (flush) begin
        pend_next[r] = PEND_WIDTH'(cnt_inc);
      end else if (cnt_base > cnt_dec) begin
        pend_next[r] = PEND_WIDTH'(cnt_base - cnt_dec);
      end else begin
        pend_next[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_count <= '0;
      wr_done    <= '0;
    end else begin
      pend_count <= pend_next;
      wr_done    <= wr_en;
    end
  end

  // Ports are visited in ascending order so the highest-index writer of a
  // register is the last nonblocking assignment and wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      registers    <= '0;
      registers[2] <= stackptr;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wa[w] != '0)) begin
          registers[wa[w]] <= wd[w];
        end
      end
    end
  end

  // With bypass, a read that matches a writeback this cycle returns the
  // winning write data and is only busy if writers remain after this
  // cycle's commits retire.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    rd_addr = '0;
    rd_hits = '0;
    rd_byp  = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_addr = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd_hits = '0;
      rd_byp  = registers[rd_addr];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wa[w] == rd_addr)) begin
          rd_hits = rd_hits + CW'(1);
          rd_byp  = wd[w];
        end
      end
      if (rd_addr == '0) begin
        rs_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rs_busy[i]                          = 1'b0;
      end else if (BYPASS && (rd_hits != '0)) begin
        rs_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_byp;
        rs_busy[i]                          = CW'(pend_count[rd_addr]) > rd_hits;
      end else begin
        rs_data[i*DATA_WIDTH +: DATA_WIDTH] = registers[rd_addr];
        rs_busy[i]                          = pend_count[rd_addr] != '0;
      end
    end
  end

  assign raw_hazard = |rs_busy;

endmodule
